// File: rtl/systolic_host_driver.sv
// systolic_host_driver
//   Host-side sequencer for the 3x3 systolic accelerator. The host writes
//   weight words and the activation vector into local buffers. A start pulse
//   then runs one job: reset the accelerator, stream the weights, wait for the
//   pipeline, capture the result words, and hand them back to the host over a
//   valid/ready port.
//
// Ports
//   clk, reset              clock (posedge), synchronous active-high reset
//   cfg_wvalid/wready       host config write handshake (ready only in IDLE)
//   cfg_waddr/cfg_wdata     0..N_WGT-1 weight word, N_WGT activation, else invalid
//   cfg_err                 pulse on an accepted write to an invalid address
//   start, busy, done       job start pulse / job in progress / last word accepted
//   acc_rst, acc_data,
//   acc_in, acc_out         accelerator reset, weight bus, activation, result bus
//   res_valid/ready/data/last  result stream back to the host
module systolic_host_driver #(
    parameter int N_WGT     = 5,
    parameter int N_RES     = 5,
    parameter int RES_DELAY = 10,
    parameter int IN_W      = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_wvalid,
    output logic            cfg_wready,
    input  logic [2:0]      cfg_waddr,
    input  logic [31:0]     cfg_wdata,
    output logic            cfg_err,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            acc_rst,
    output logic [31:0]     acc_data,
    output logic [IN_W-1:0] acc_in,
    input  logic [31:0]     acc_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_data,
    output logic            res_last
);

    typedef enum logic [2:0] {IDLE, ARST, LOAD, WAIT, CAP, DRAIN} state_t;

    localparam logic [2:0] LAST_W   = 3'(N_WGT - 1);
    localparam logic [2:0] LAST_R   = 3'(N_RES - 1);
    localparam logic [2:0] ACT_ADDR = 3'(N_WGT);
    // WAIT spans RES_DELAY-1 cycles, which does not fit the 3-bit word
    // counter, so it gets its own wider counter.
    localparam int         WC_W     = $clog2(RES_DELAY);
    localparam logic [WC_W-1:0] LAST_WAIT = WC_W'(RES_DELAY - 2);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;      // weight index k, capture index j, drain idx
    logic [WC_W-1:0]   wcnt_q, wcnt_d;

    logic [31:0]       wbuf [N_WGT];
    logic [IN_W-1:0]   actbuf;
    logic [31:0]       rbuf [N_RES];

    logic              wr_accept;

    assign cfg_wready = (state_q == IDLE);
    assign wr_accept  = cfg_wvalid & cfg_wready;
    assign cfg_err    = wr_accept & (cfg_waddr > ACT_ADDR);
    assign busy       = (state_q != IDLE);
    assign acc_rst    = reset | (state_q == ARST);
    assign acc_in     = actbuf;
    assign res_valid  = (state_q == DRAIN);
    assign res_last   = (state_q == DRAIN) & (cnt_q == LAST_R);
    assign done       = (state_q == DRAIN) & res_ready & (cnt_q == LAST_R);

    always_comb begin
        acc_data = '0;
        if (state_q == LOAD) begin
            for (int unsigned i = 0; i < N_WGT; i++) begin
                if (cnt_q == 3'(i)) acc_data = wbuf[i];
            end
        end
    end

    always_comb begin
        res_data = '0;
        if (state_q == DRAIN) begin
            for (int unsigned i = 0; i < N_RES; i++) begin
                if (cnt_q == 3'(i)) res_data = rbuf[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARST;
                    cnt_d   = '0;
                end
            end
            ARST: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: begin
                if (cnt_q == LAST_W) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WAIT: begin
                if (wcnt_q == LAST_WAIT) begin
                    state_d = CAP;
                    cnt_d   = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            CAP: begin
                if (cnt_q == LAST_R) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DRAIN: begin
                if (res_ready) begin
                    if (cnt_q == LAST_R) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            actbuf  <= '0;
            for (int unsigned i = 0; i < N_WGT; i++) wbuf[i] <= '0;
            for (int unsigned i = 0; i < N_RES; i++) rbuf[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            if (wr_accept) begin
                for (int unsigned i = 0; i < N_WGT; i++) begin
                    if (cfg_waddr == 3'(i)) wbuf[i] <= cfg_wdata;
                end
                if (cfg_waddr == ACT_ADDR) actbuf <= cfg_wdata[IN_W-1:0];
            end
            // Capture is unconditional: the accelerator has no backpressure.
            if (state_q == CAP) begin
                for (int unsigned i = 0; i < N_RES; i++) begin
                    if (cnt_q == 3'(i)) rbuf[i] <= acc_out;
                end
            end
        end
    end

endmodule
